// File: rtl/dmem_burst_master.sv
// dmem_burst_master
//
// Initiator for the single-port data memory. It accepts a burst command
// (start word address plus beat count minus one) on a valid/ready handshake
// and then moves one word per cycle between the memory port and a streaming
// channel. Addresses increment and wrap modulo 2^ADDR_W.
//
// Ports:
//   CLK, RST          clock (posedge) and asynchronous active-low reset
//   cmd_valid/ready   burst command handshake; ready only while idle
//   cmd_write         1 = write burst, 0 = read burst
//   cmd_addr          start word address
//   cmd_len           beats minus one
//   wr_valid/ready    write-data channel (ready only during a write burst)
//   wr_data           write-data word
//   rd_valid/ready    registered read-data channel
//   rd_data           read word, held stable until consumed
//   busy              high whenever a burst is in progress
//   done              one-cycle pulse when a burst completes
//   mem_read          memory read strobe
//   mem_write         memory write strobe
//   mem_addr          memory word address
//   mem_wdata         memory write data
//   mem_rdata         memory read data, combinational from mem_addr

module dmem_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    RD_DRAIN = 2'd2,
    WRITE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  beats_left, beats_left_nxt;
  logic              rd_valid_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic              done_nxt;
  logic              rd_issue;

  // Word address step; the natural width overflow gives the wrap to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // Beat counter step that saturates at zero.
  function automatic logic [LEN_W-1:0] beats_dec(input logic [LEN_W-1:0] b);
    if (b == '0) return '0;
    return b - {{(LEN_W-1){1'b0}}, 1'b1};
  endfunction

  // A read beat may issue whenever the output register is empty or is being
  // emptied this cycle, which gives refill-while-consume at full rate.
  assign rd_issue = !rd_valid || rd_ready;

  always_comb begin
    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    beats_left_nxt = beats_left;
    rd_valid_nxt   = rd_valid;
    rd_data_nxt    = rd_data;
    done_nxt       = 1'b0;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = cur_addr;
    mem_wdata      = '0;
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_nxt   = cmd_addr;
          beats_left_nxt = cmd_len;
          state_nxt      = cmd_write ? WRITE : READ;
        end
      end

      READ: begin
        if (rd_issue) begin
          mem_read       = 1'b1;
          rd_data_nxt    = mem_rdata;
          rd_valid_nxt   = 1'b1;
          cur_addr_nxt   = addr_inc(cur_addr);
          beats_left_nxt = beats_dec(beats_left);
          if (beats_left == '0) state_nxt = RD_DRAIN;
        end
      end

      // Last word is sitting in rd_data; completion waits for its consumer.
      RD_DRAIN: begin
        if (rd_valid && rd_ready) begin
          rd_valid_nxt = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end

      // Write data flows straight through; the memory captures on this edge.
      WRITE: begin
        wr_ready  = 1'b1;
        mem_write = wr_valid;
        mem_wdata = wr_data;
        if (wr_valid) begin
          cur_addr_nxt   = addr_inc(cur_addr);
          beats_left_nxt = beats_dec(beats_left);
          if (beats_left == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      beats_left <= beats_left_nxt;
      rd_valid   <= rd_valid_nxt;
      rd_data    <= rd_data_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_burst_master.sv
// Testbench for dmem_burst_master: a behavioural 32-word memory, a bench-owned
// reference copy of memory contents, and scoreboards for expected write beats
// and expected read words.

module tb_dmem_burst_master;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem     [0:31];
  logic [DATA_W-1:0] ref_mem [0:31];
  logic              preload = 1'b1;
  int                wr_count = 0;
  int                rd_count = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wexp_t;

  wexp_t             wq[$];
  logic [DATA_W-1:0] rq[$];

  always #5 CLK = ~CLK;

  dmem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_write) wr_count <= wr_count + 1;
    if (mem_read)  rd_count <= rd_count + 1;
  end

  task automatic push_reads(input logic [ADDR_W-1:0] a, input int n);
    logic [ADDR_W-1:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + ADDR_W'(i);
      rq.push_back(ref_mem[ad]);
    end
  endtask

  // Offers a command and returns one step after the accepting edge.
  task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [LEN_W-1:0] l);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready stayed low for 50 cycles, required 1");
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] a, input int n,
                           input bit gaps, input logic [DATA_W-1:0] base);
    int c0;
    wexp_t e;
    logic [ADDR_W-1:0] ad;
    c0 = wr_count;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        wr_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem_write !== 1'b0 || wr_ready !== 1'b1) begin
          failures++;
          $display("FAIL wr_gap: mem_write=%b wr_ready=%b, required 0/1", mem_write, wr_ready);
        end
        @(posedge CLK); #1;
      end
      ad = a + ADDR_W'(i);
      wr_valid = 1'b1;
      wr_data = base + DATA_W'(i);
      wq.push_back('{ad, base + DATA_W'(i)});
      ref_mem[ad] = base + DATA_W'(i);
      @(negedge CLK);
      checks++;
      if (mem_write !== 1'b1 || wr_ready !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL wr_beat%0d: mem_write=%b wr_ready=%b done=%b, required 1/1/0",
                 i, mem_write, wr_ready, done);
      end
      e = wq.pop_front();
      checks++;
      if (mem_addr !== e.a || mem_wdata !== e.d) begin
        failures++;
        $display("FAIL wr_addr_data%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, mem_addr, mem_wdata, e.a, e.d);
      end
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_write !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_done: done=%b busy=%b mem_write=%b cmd_ready=%b, required 1/0/0/1",
               done, busy, mem_write, cmd_ready);
    end
    checks++;
    if (wr_count - c0 != n) begin
      failures++;
      $display("FAIL wr_count: %0d writes, required %0d", wr_count - c0, n);
    end
    @(posedge CLK); #1;
  endtask

  // Collects n read words; bp applies the 1,0,0,1 rd_ready pattern.
  task automatic run_read(input int n, input bit bp);
    int got, k, c0;
    bit stalled;
    bit pat [0:3];
    logic [DATA_W-1:0] held, exp;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = 0; k = 0; stalled = 1'b0; held = '0; c0 = rd_count;
    while (got < n && k < 200) begin
      rd_ready = bp ? pat[k % 4] : 1'b1;
      @(negedge CLK);
      if (stalled) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== held) begin
          failures++;
          $display("FAIL rd_stable: rd_valid=%b rd_data=%h, required 1/%h", rd_valid, rd_data, held);
        end
      end
      checks++;
      if (cmd_ready !== 1'b0 || done !== 1'b0 || (mem_read & mem_write) !== 1'b0) begin
        failures++;
        $display("FAIL rd_busy_flags: cmd_ready=%b done=%b rd&wr=%b, required 0/0/0",
                 cmd_ready, done, mem_read & mem_write);
      end
      if (rd_valid === 1'b1 && rd_ready) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rd_word%0d: got %h, required no word", got, rd_data);
        end else begin
          exp = rq.pop_front();
          if (rd_data !== exp) begin
            failures++;
            $display("FAIL rd_word%0d: got %h, required %h", got, rd_data, exp);
          end
        end
        got++;
      end
      stalled = (rd_valid === 1'b1) && !rd_ready;
      held = rd_data;
      @(posedge CLK); #1;
      k++;
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL rd_timeout: received %0d words, required %0d", got, n);
    end
    rd_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_done: done=%b busy=%b rd_valid=%b cmd_ready=%b, required 1/0/0/1",
               done, busy, rd_valid, cmd_ready);
    end
    checks++;
    if (rd_count - c0 != n) begin
      failures++;
      $display("FAIL rd_issue_count: %0d mem_read cycles, required %0d", rd_count - c0, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; preload = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || rd_data !== '0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: rd_valid=%b done=%b busy=%b mrd=%b mwr=%b rd_data=%h cmd_ready=%b",
               rd_valid, done, busy, mem_read, mem_write, rd_data, cmd_ready);
    end
    @(posedge CLK); #1;
    RST = 1'b1; preload = 1'b0;
    // Start an 8-beat read, stall it, then reset while rd_valid is high.
    rd_ready = 1'b0;
    send_cmd(1'b0, 5'd0, 3'd7);
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    checks++;
    if (rd_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: rd_valid=%b busy=%b, required 1/1", rd_valid, busy);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_async: rd_valid=%b done=%b busy=%b mrd=%b mwr=%b rd_data=%h, required all 0",
               rd_valid, done, busy, mem_read, mem_write, rd_data);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b rd_valid=%b done=%b, required 1/0/0/0",
               cmd_ready, busy, rd_valid, done);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single_write();
    send_cmd(1'b1, 5'd5, 3'd0);
    run_write(5'd5, 1, 1'b0, 32'hDEAD_BEEF);
    checks++;
    if (mem[5] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_write_mem: mem[5]=%h, required deadbeef", mem[5]);
    end
  endtask

  task automatic test_single_read();
    logic [DATA_W-1:0] exp;
    push_reads(5'd5, 1);
    send_cmd(1'b0, 5'd5, 3'd0);
    rd_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 5'd5 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_lat_n1: mem_read=%b mem_addr=%0d rd_valid=%b, required 1/5/0",
               mem_read, mem_addr, rd_valid);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    exp = rq.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL rd_lat_n2: rd_valid=%b rd_data=%h mem_read=%b, required 1/%h/0",
               rd_valid, rd_data, mem_read, exp);
    end
    @(posedge CLK); #1;
    rd_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_single_done: done=%b rd_valid=%b busy=%b, required 1/0/0",
               done, rd_valid, busy);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_wrap_write();
    send_cmd(1'b1, 5'd30, 3'd3);
    run_write(5'd30, 4, 1'b1, 32'd1);
    checks++;
    if (mem[30] !== 32'd1 || mem[31] !== 32'd2 || mem[0] !== 32'd3 || mem[1] !== 32'd4) begin
      failures++;
      $display("FAIL wrap_mem: %h %h %h %h, required 1 2 3 4", mem[30], mem[31], mem[0], mem[1]);
    end
  endtask

  task automatic test_read_backpressure();
    push_reads(5'd0, 8);
    send_cmd(1'b0, 5'd0, 3'd7);
    run_read(8, 1'b1);
    @(posedge CLK); #1;
  endtask

  task automatic test_cmd_during_busy();
    push_reads(5'd0, 8);
    send_cmd(1'b0, 5'd0, 3'd7);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd20; cmd_len = 3'd0;
    push_reads(5'd20, 1);
    run_read(8, 1'b0);
    // Still held high: accepted on the edge ending the done cycle.
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    run_read(1, 1'b0);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_burst();
    int c0;
    logic [DATA_W-1:0] old12;
    old12 = ref_mem[12];
    send_cmd(1'b1, 5'd10, 3'd3);
    c0 = wr_count;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data = 32'h0000_5000 + DATA_W'(i);
      ref_mem[10 + i] = 32'h0000_5000 + DATA_W'(i);
      @(posedge CLK); #1;
    end
    wr_data = 32'h0000_5002;
    RST = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: mem_write=%b busy=%b done=%b wr_ready=%b, required 0/0/0/0",
               mem_write, busy, done, wr_ready);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL midrst_idle%0d: done=%b busy=%b cmd_ready=%b, required 0/0/1",
                 k, done, busy, cmd_ready);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (wr_count - c0 != 2) begin
      failures++;
      $display("FAIL midrst_count: %0d writes, required 2", wr_count - c0);
    end
    checks++;
    if (mem[10] !== ref_mem[10] || mem[11] !== ref_mem[11] || mem[12] !== old12) begin
      failures++;
      $display("FAIL midrst_mem: %h %h %h, required %h %h %h",
               mem[10], mem[11], mem[12], ref_mem[10], ref_mem[11], old12);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    test_reset();
    test_single_write();
    test_single_read();
    test_wrap_write();
    test_read_backpressure();
    test_cmd_during_busy();
    test_reset_mid_burst();
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: rq=%0d wq=%0d entries, required 0/0", rq.size(), wq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
